// File: rtl/gpio_port.sv
// gpio_port: N-channel GPIO controller between the CPU register bus and the pad cells.
// Holds the output, output-enable, pull and interrupt registers, and runs every pad input
// through a synchroniser, a stability filter and a polarity-selectable edge detector.
module gpio_port #(
    parameter int unsigned N           = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4,
    parameter int unsigned DB_W        = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [2:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [2:0]   rd_addr,
    output logic [N-1:0] rd_data,
    input  logic [N-1:0] pad_in,
    output logic [N-1:0] pad_out,
    output logic [N-1:0] pad_oe,
    output logic [N-1:0] pad_pullup,
    output logic [N-1:0] pad_pulldown,
    output logic         irq
);

    typedef enum logic [2:0] {
        REG_OUT      = 3'd0,
        REG_OE       = 3'd1,
        REG_IN       = 3'd2,
        REG_IRQ_EN   = 3'd3,
        REG_IRQ_POL  = 3'd4,
        REG_IRQ_STAT = 3'd5,
        REG_PU       = 3'd6,
        REG_PD       = 3'd7
    } reg_addr_e;

    logic [N-1:0] out_q;
    logic [N-1:0] oe_q;
    logic [N-1:0] irq_en_q;
    logic [N-1:0] irq_pol_q;
    logic [N-1:0] irq_stat_q;
    logic [N-1:0] pu_q;
    logic [N-1:0] pd_q;

    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] s;
    logic [N-1:0] db;
    logic [N-1:0] db_d;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] ev;
    logic [N-1:0] w1c;

    // Plain read/write control registers; IN and IRQ_STAT are not written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            oe_q      <= '0;
            irq_en_q  <= '0;
            irq_pol_q <= '0;
            pu_q      <= '0;
            pd_q      <= '0;
        end else if (wr_en) begin
            unique case (reg_addr_e'(wr_addr))
                REG_OUT:     out_q     <= wr_data;
                REG_OE:      oe_q      <= wr_data;
                REG_IRQ_EN:  irq_en_q  <= wr_data;
                REG_IRQ_POL: irq_pol_q <= wr_data;
                REG_PU:      pu_q      <= wr_data;
                REG_PD:      pd_q      <= wr_data;
                default:     ;
            endcase
        end
    end

    // Synchroniser chain bringing the asynchronous pad values into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= pad_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DB_CYCLES == 0) begin : g_bypass
            // With no filtering the last synchroniser flop is the debounced value,
            // keeping the pad-to-IN latency at exactly SYNC_STAGES cycles.
            assign db = s;
        end else begin : g_filter
            localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

            logic [DB_W-1:0] cnt [N];
            logic [N-1:0]    db_q;

            // Per-bit stability counter: accept a new level only after DB_CYCLES
            // consecutive samples disagree with the current debounced value.
            always_ff @(posedge clk) begin
                if (rst) begin
                    db_q <= '0;
                    for (int unsigned i = 0; i < N; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < N; i++) begin
                        if (s[i] == db_q[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            db_q[i] <= s[i];
                            cnt[i]  <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                end
            end

            assign db = db_q;
        end
    endgenerate

    // One-cycle delayed copy of the debounced input for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_d <= '0;
        end else begin
            db_d <= db;
        end
    end

    assign rise = db & ~db_d;
    assign fall = ~db & db_d;
    assign ev   = (irq_pol_q & fall) | (~irq_pol_q & rise);

    // Write-1-to-clear mask for the interrupt status register.
    always_comb begin
        w1c = '0;
        if (wr_en && (reg_addr_e'(wr_addr) == REG_IRQ_STAT)) begin
            w1c = wr_data;
        end
    end

    // Interrupt status: a new event in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_stat_q <= '0;
        end else begin
            irq_stat_q <= (irq_stat_q & ~w1c) | ev;
        end
    end

    // Combinational register read mux.
    always_comb begin
        rd_data = '0;
        unique case (reg_addr_e'(rd_addr))
            REG_OUT:      rd_data = out_q;
            REG_OE:       rd_data = oe_q;
            REG_IN:       rd_data = db;
            REG_IRQ_EN:   rd_data = irq_en_q;
            REG_IRQ_POL:  rd_data = irq_pol_q;
            REG_IRQ_STAT: rd_data = irq_stat_q;
            REG_PU:       rd_data = pu_q;
            REG_PD:       rd_data = pd_q;
            default:      rd_data = '0;
        endcase
    end

    assign pad_out      = out_q;
    assign pad_oe       = oe_q;
    assign pad_pullup   = pu_q;
    assign pad_pulldown = pd_q & ~pu_q;
    assign irq          = |(irq_stat_q & irq_en_q);

endmodule
